// File: rtl/acc_writeback.sv
// acc_writeback: writeback stage of a small accumulator machine.
// A result from the execute stage can update the accumulator and the carry
// flag, and can start a single outstanding data-memory write. While that
// write waits for memWrAck the stage stalls upstream. A write that is never
// acknowledged is abandoned after ACK_TIMEOUT cycles and raises a sticky memErr.
module acc_writeback #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       exValid,
  output logic       exReady,
  input  logic [7:0] aluOut,
  input  logic       carryOut,
  input  logic       wbAcc,
  input  logic       wbCarry,
  input  logic       wbStore,
  input  logic [7:0] storeAddr,
  input  logic       flush,
  output logic [7:0] accOut,
  output logic [7:0] accFwd,
  output logic       carryFlag,
  output logic       memWrReq,
  output logic [7:0] memWrAddr,
  output logic [7:0] memWrData,
  input  logic       memWrAck,
  output logic       memErr
);

  localparam logic       STATE_IDLE  = 1'b0;
  localparam logic       STATE_STORE = 1'b1;
  localparam logic [7:0] TIMEOUT_CNT = 8'(ACK_TIMEOUT);

  logic       state_q, state_d;
  logic [7:0] acc_q, acc_d;
  logic       carry_q, carry_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic       accept;
  logic [7:0] cnt_inc;

  // A result is taken only while idle and only when it is not being flushed.
  assign accept  = exValid & (state_q == STATE_IDLE) & ~flush;
  assign cnt_inc = cnt_q + 8'd1;

  // Next-state logic: accept handling in IDLE, ack/timeout tracking in STORE.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      STATE_IDLE: begin
        if (accept) begin
          if (wbAcc) begin
            acc_d = aluOut;
          end
          if (wbCarry) begin
            carry_d = carryOut;
          end
          if (wbStore) begin
            addr_d  = storeAddr;
            data_d  = aluOut;
            cnt_d   = 8'd0;
            state_d = STATE_STORE;
          end
        end
      end
      default: begin
        // An ack wins even on the cycle the wait count would expire.
        if (memWrAck) begin
          cnt_d   = 8'd0;
          state_d = STATE_IDLE;
        end else if (cnt_inc == TIMEOUT_CNT) begin
          cnt_d   = 8'd0;
          err_d   = 1'b1;
          state_d = STATE_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
    endcase
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= STATE_IDLE;
      acc_q   <= 8'h00;
      carry_q <= 1'b0;
      addr_q  <= 8'h00;
      data_q  <= 8'h00;
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign exReady   = (state_q == STATE_IDLE);
  assign memWrReq  = (state_q == STATE_STORE);
  assign memWrAddr = addr_q;
  assign memWrData = data_q;
  assign accOut    = acc_q;
  assign carryFlag = carry_q;
  assign memErr    = err_q;
  assign accFwd    = (accept & wbAcc) ? aluOut : acc_q;

endmodule

// File: tb/tb_acc_writeback.sv
// Self-checking bench for acc_writeback. Expected memory writes are pushed
// into a queue when a store is accepted and popped when the write handshake
// completes; all other expectations are constants derived from the behaviour.
module tb_acc_writeback;

  logic       clk = 1'b0;
  logic       reset;
  logic       exValid;
  logic       exReady;
  logic [7:0] aluOut;
  logic       carryOut;
  logic       wbAcc;
  logic       wbCarry;
  logic       wbStore;
  logic [7:0] storeAddr;
  logic       flush;
  logic [7:0] accOut;
  logic [7:0] accFwd;
  logic       carryFlag;
  logic       memWrReq;
  logic [7:0] memWrAddr;
  logic [7:0] memWrData;
  logic       memWrAck;
  logic       memErr;

  int checks = 0;
  int fails  = 0;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;
  wr_t exp_q[$];

  acc_writeback #(.ACK_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .exValid(exValid), .exReady(exReady),
    .aluOut(aluOut), .carryOut(carryOut), .wbAcc(wbAcc), .wbCarry(wbCarry),
    .wbStore(wbStore), .storeAddr(storeAddr), .flush(flush),
    .accOut(accOut), .accFwd(accFwd), .carryFlag(carryFlag),
    .memWrReq(memWrReq), .memWrAddr(memWrAddr), .memWrData(memWrData),
    .memWrAck(memWrAck), .memErr(memErr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    exValid = 0; flush = 0; wbAcc = 0; wbCarry = 0; wbStore = 0;
    aluOut = 8'h00; carryOut = 0; storeAddr = 8'h00; memWrAck = 0;
  endtask

  task automatic pop_and_check(input string name);
    wr_t e;
    checks++;
    if (exp_q.size() == 0) begin
      fails++; $display("FAIL %s: write completed addr=%h data=%h but none expected", name, memWrAddr, memWrData);
    end else begin
      e = exp_q.pop_front();
      if (memWrAddr !== e.addr || memWrData !== e.data) begin
        fails++; $display("FAIL %s: got addr=%h data=%h expected addr=%h data=%h", name, memWrAddr, memWrData, e.addr, e.data);
      end
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    step(); step();
    reset = 0;
    checks++; if (accOut !== 8'h00) begin fails++; $display("FAIL reset_acc: got %h expected 00", accOut); end
    checks++; if (carryFlag !== 1'b0) begin fails++; $display("FAIL reset_carry: got %b expected 0", carryFlag); end
    checks++; if (memWrReq !== 1'b0 || memWrAddr !== 8'h00 || memWrData !== 8'h00) begin fails++; $display("FAIL reset_mem: got req=%b addr=%h data=%h expected 0/00/00", memWrReq, memWrAddr, memWrData); end
    checks++; if (memErr !== 1'b0) begin fails++; $display("FAIL reset_err: got %b expected 0", memErr); end
    checks++; if (exReady !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", exReady); end
  endtask

  task automatic test_acc_carry();
    exValid = 1; aluOut = 8'h3C; wbAcc = 1; wbCarry = 1; carryOut = 1;
    #1;
    checks++; if (accFwd !== 8'h3C) begin fails++; $display("FAIL fwd_same_cycle: got %h expected 3c", accFwd); end
    step();
    idle_inputs();
    #1;
    checks++; if (accOut !== 8'h3C) begin fails++; $display("FAIL acc_load: got %h expected 3c", accOut); end
    checks++; if (carryFlag !== 1'b1) begin fails++; $display("FAIL carry_load: got %b expected 1", carryFlag); end
    checks++; if (exReady !== 1'b1) begin fails++; $display("FAIL ready_after_acc: got %b expected 1", exReady); end
    // Accept with no writeback enables must leave acc and carry alone.
    exValid = 1; aluOut = 8'h77; carryOut = 0;
    step();
    idle_inputs();
    #1;
    checks++; if (accOut !== 8'h3C || carryFlag !== 1'b1) begin fails++; $display("FAIL hold_no_wb: got acc=%h carry=%b expected 3c/1", accOut, carryFlag); end
  endtask

  task automatic test_store_ack();
    exValid = 1; aluOut = 8'hA5; wbStore = 1; storeAddr = 8'h10;
    exp_q.push_back('{addr: 8'h10, data: 8'hA5});
    step();
    idle_inputs();
    // Upstream presents a new result while stalled; it must be ignored.
    exValid = 1; aluOut = 8'h77; wbAcc = 1; flush = 1;
    for (int i = 1; i <= 3; i++) begin
      if (i == 3) memWrAck = 1;
      #1;
      checks++; if (memWrReq !== 1'b1 || memWrAddr !== 8'h10 || memWrData !== 8'hA5) begin fails++; $display("FAIL store_req_c%0d: got req=%b addr=%h data=%h expected 1/10/a5", i, memWrReq, memWrAddr, memWrData); end
      checks++; if (exReady !== 1'b0 || accFwd !== 8'h3C) begin fails++; $display("FAIL store_stall_c%0d: got ready=%b fwd=%h expected 0/3c", i, exReady, accFwd); end
      if (i == 3) pop_and_check("store_data");
      step();
    end
    idle_inputs();
    #1;
    checks++; if (memWrReq !== 1'b0 || exReady !== 1'b1 || memErr !== 1'b0) begin fails++; $display("FAIL store_done: got req=%b ready=%b err=%b expected 0/1/0", memWrReq, exReady, memErr); end
    checks++; if (accOut !== 8'h3C) begin fails++; $display("FAIL store_acc_untouched: got %h expected 3c", accOut); end
    // A stray ack with no request outstanding does nothing.
    memWrAck = 1;
    step();
    memWrAck = 0;
    checks++; if (memWrReq !== 1'b0 || exReady !== 1'b1 || memErr !== 1'b0) begin fails++; $display("FAIL stray_ack: got req=%b ready=%b err=%b expected 0/1/0", memWrReq, exReady, memErr); end
  endtask

  task automatic test_store_acc_edge_ack();
    int n;
    exValid = 1; aluOut = 8'h5A; wbAcc = 1; wbStore = 1; storeAddr = 8'h20;
    exp_q.push_back('{addr: 8'h20, data: 8'h5A});
    step();
    idle_inputs();
    checks++; if (accOut !== 8'h5A || memWrData !== 8'h5A || memWrReq !== 1'b1) begin fails++; $display("FAIL store_and_acc: got acc=%h data=%h req=%b expected 5a/5a/1", accOut, memWrData, memWrReq); end
    n = 1;
    while (n < 15 && memWrReq === 1'b1) begin
      step();
      n++;
    end
    checks++; if (n !== 15 || memWrReq !== 1'b1) begin fails++; $display("FAIL edge_req_held: got %0d cycles req=%b expected 15/1", n, memWrReq); end
    memWrAck = 1;
    #1;
    pop_and_check("edge_ack_data");
    step();
    memWrAck = 0;
    checks++; if (memErr !== 1'b0 || memWrReq !== 1'b0 || exReady !== 1'b1) begin fails++; $display("FAIL edge_ack_success: got err=%b req=%b ready=%b expected 0/0/1", memErr, memWrReq, exReady); end
  endtask

  task automatic test_timeout();
    int n;
    // An abandoned write never completes, so nothing is queued for it.
    exValid = 1; aluOut = 8'hC3; wbStore = 1; storeAddr = 8'h33;
    step();
    idle_inputs();
    n = 0;
    while (memWrReq === 1'b1 && n < 40) begin
      n++;
      step();
    end
    checks++; if (n !== 15) begin fails++; $display("FAIL timeout_len: got %0d request cycles expected 15", n); end
    checks++; if (memErr !== 1'b1 || exReady !== 1'b1) begin fails++; $display("FAIL timeout_err: got err=%b ready=%b expected 1/1", memErr, exReady); end
    exValid = 1; aluOut = 8'h44; wbAcc = 1;
    step();
    idle_inputs();
    step();
    checks++; if (memErr !== 1'b1 || accOut !== 8'h44) begin fails++; $display("FAIL err_sticky: got err=%b acc=%h expected 1/44", memErr, accOut); end
  endtask

  task automatic test_flush();
    exValid = 1; aluOut = 8'h12; wbAcc = 1;
    step();
    exValid = 1; flush = 1; wbAcc = 1; wbStore = 1; wbCarry = 1; carryOut = 0; aluOut = 8'hFF; storeAddr = 8'h55;
    #1;
    checks++; if (accFwd !== 8'h12) begin fails++; $display("FAIL flush_fwd: got %h expected 12", accFwd); end
    step();
    idle_inputs();
    #1;
    checks++; if (accOut !== 8'h12 || memWrReq !== 1'b0 || exReady !== 1'b1 || carryFlag !== 1'b1) begin fails++; $display("FAIL flush_suppress: got acc=%h req=%b ready=%b carry=%b expected 12/0/1/1", accOut, memWrReq, exReady, carryFlag); end
  endtask

  task automatic test_reset_in_store();
    exValid = 1; aluOut = 8'h99; wbAcc = 1; wbStore = 1; storeAddr = 8'h44;
    step();
    idle_inputs();
    step();
    reset = 1; memWrAck = 1;
    step();
    reset = 0; memWrAck = 0;
    checks++; if (memWrReq !== 1'b0 || accOut !== 8'h00 || memErr !== 1'b0 || exReady !== 1'b1) begin fails++; $display("FAIL reset_in_store: got req=%b acc=%h err=%b ready=%b expected 0/00/0/1", memWrReq, accOut, memErr, exReady); end
    // Reset beats a simultaneous accept.
    exValid = 1; aluOut = 8'hEE; wbAcc = 1; wbStore = 1; reset = 1;
    step();
    reset = 0;
    idle_inputs();
    #1;
    checks++; if (accOut !== 8'h00 || memWrReq !== 1'b0) begin fails++; $display("FAIL reset_vs_accept: got acc=%h req=%b expected 00/0", accOut, memWrReq); end
  endtask

  task automatic test_back_to_back();
    exValid = 1; wbAcc = 1; aluOut = 8'h01;
    #1;
    checks++; if (accFwd !== 8'h01 || accOut !== 8'h00) begin fails++; $display("FAIL b2b_first: got fwd=%h acc=%h expected 01/00", accFwd, accOut); end
    step();
    aluOut = 8'h02;
    #1;
    checks++; if (accFwd !== 8'h02 || accOut !== 8'h01) begin fails++; $display("FAIL b2b_second: got fwd=%h acc=%h expected 02/01", accFwd, accOut); end
    step();
    idle_inputs();
    #1;
    checks++; if (accFwd !== 8'h02 || accOut !== 8'h02) begin fails++; $display("FAIL b2b_settle: got fwd=%h acc=%h expected 02/02", accFwd, accOut); end
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_acc_carry();
    test_store_ack();
    test_store_acc_edge_ack();
    test_timeout();
    test_flush();
    test_reset_in_store();
    test_back_to_back();
    checks++; if (exp_q.size() != 0) begin fails++; $display("FAIL scoreboard_empty: got %0d pending writes expected 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/acc_writeback.md
ACC_WRITEBACK -- requirements
Module: acc_writeback

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 15, meaning cycles STORE waits for memWrAck before abandoning the write (legal range 1-255).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 SHALL have port exValid  input  1  execute stage presents a completed ALU result this cycle.
REQ-005 SHALL have port exReady  output  1  block can accept a result this cycle.
REQ-006 SHALL have port aluOut  input  8  ALU result byte.
REQ-007 SHALL have port carryOut  input  1  ALU carry/borrow (meaningful for ADD/SUB only).
REQ-008 SHALL have port wbAcc  input  1  write aluOut into accumulator.
REQ-009 SHALL have port wbCarry  input  1  write carryOut into carry flag.
REQ-010 SHALL have port wbStore  input  1  write aluOut to data memory at storeAddr.
REQ-011 SHALL have port storeAddr  input  8  data-memory address for store.
REQ-012 SHALL have port flush  input  1  discard the result presented this cycle.
REQ-013 SHALL have port accOut  output  8  registered accumulator (feeds ALU op1).
REQ-014 SHALL have port accFwd  output  8  combinational next-accumulator value for forwarding.
REQ-015 SHALL have port carryFlag  output  1  registered carry flag.
REQ-016 SHALL have ports memWrReq output 1, memWrAddr output 8, memWrData output 8, memWrAck input 1  memory write handshake.
REQ-017 SHALL have port memErr  output  1  sticky: a store timed out.

Function
REQ-018 SHALL implement FSM states IDLE and STORE; exReady = 1 only in IDLE.
REQ-019 Accept = exValid & exReady & ~flush; all updates below occur only on an accept edge.
REQ-020 On accept with wbAcc=1, accOut SHALL equal aluOut from the next cycle; wbAcc=0 leaves accOut unchanged.
REQ-021 On accept with wbCarry=1, carryFlag SHALL take carryOut next cycle; otherwise hold.
REQ-022 accFwd SHALL equal aluOut when accept & wbAcc, else accOut (zero-cycle forwarding).
REQ-023 On accept with wbStore=1, SHALL capture storeAddr/aluOut into memWrAddr/memWrData, go to STORE, assert memWrReq from the next cycle.
REQ-024 In STORE, memWrReq, memWrAddr, memWrData SHALL stay stable until the cycle memWrAck=1 is sampled; next cycle IDLE, memWrReq=0.
REQ-025 memWrAck while memWrReq=0 SHALL be ignored.
REQ-026 Accumulator/carry and store may update on the same accept; store data is aluOut, not old accOut.
REQ-027 STORE SHALL run an 8-bit wait counter cleared on entry, incremented each cycle without ack; at count ACK_TIMEOUT with no ack, SHALL set memErr, drop memWrReq, return to IDLE.
REQ-028 Ack on the same cycle the counter reaches ACK_TIMEOUT SHALL count as success (memErr unchanged).
REQ-029 flush in IDLE SHALL suppress the accept (no acc, carry, or store effect); flush in STORE SHALL NOT abort the outstanding write.
REQ-030 exValid while in STORE SHALL cause no state change; upstream must hold the result until exReady.
REQ-031 memErr SHALL clear only on reset.

Reset
REQ-032 On reset: state IDLE, accOut=8'h00, carryFlag=0, memWrReq=0, memWrAddr=8'h00, memWrData=8'h00, memErr=0, counter=0; exReady=1 the cycle after.
REQ-033 Reset asserted in STORE SHALL drop memWrReq on the next cycle and discard the pending write regardless of memWrAck.
REQ-034 Reset SHALL take priority over accept, ack and timeout in the same cycle.

Verification
REQ-035 Accept aluOut=8'h3C, wbAcc=1, wbCarry=1, carryOut=1 -> accFwd=8'h3C same cycle; accOut=8'h3C, carryFlag=1 next cycle; exReady stays 1.
REQ-036 Accept aluOut=8'hA5, wbStore=1, storeAddr=8'h10; ack after 3 cycles -> memWrReq high 3 cycles with addr 8'h10/data 8'hA5, exReady=0 throughout, IDLE the cycle after ack.
REQ-037 Store with no ack, ACK_TIMEOUT=15 -> memWrReq drops after 15 request cycles, memErr=1 and stays 1 across later accepts until reset.
REQ-038 exValid=1, flush=1, wbAcc=1, aluOut=8'hFF with accOut=8'h12 -> accOut stays 8'h12, no memWrReq.
REQ-039 Reset asserted in the second STORE cycle with memWrAck=1 -> next cycle memWrReq=0, accOut=8'h00, memErr=0, state IDLE.
REQ-040 Back-to-back accepts wbAcc=1 of 8'h01 then 8'h02 -> accFwd shows 8'h01 then 8'h02, accOut lags by one cycle each.
